// File: rtl/pipeline_flow_ctrl_pkg.sv
// Shared types for the pipeline flow controller: FSM states, redirect sources
// and the stage index constants of the classic five-stage pipeline.
package flow_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MC_WAIT    = 2'd1,
        TRAP_DRAIN = 2'd2,
        TRAP_REDIR = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BRANCH = 2'd0,
        TRAP   = 2'd1,
        MRET   = 2'd2
    } redirect_sel_t;

    localparam int IF  = 0;
    localparam int ID  = 1;
    localparam int EXE = 2;
    localparam int MEM = 3;
    localparam int WB  = 4;

    // Drain counter width; it covers the full 0..15 range of drain cycles.
    localparam int DRAIN_W = 4;

endpackage

// File: rtl/pipeline_flow_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// Pipeline hazard/flow controller: per-register enables and flushes, PC enable,
// redirect selection for branch/trap/mret, and a stall-cycle counter.
module pipeline_flow_ctrl
    import flow_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int EXE_STAGE    = 2,
    parameter int BR_STAGE     = 3,
    parameter int DRAIN_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_pipl,
    input  logic                  load_hazard,
    input  logic                  branch_taken,
    input  logic                  mc_start,
    input  logic                  mc_done,
    input  logic                  trap_req,
    input  logic                  mret_req,
    input  logic                  cnt_clr,
    output logic [NUM_STAGES-2:0] reg_en,
    output logic [NUM_STAGES-2:0] reg_clr,
    output logic                  pc_reg_en,
    output logic                  redirect_valid,
    output logic [1:0]            redirect_sel,
    output logic                  trap_ack,
    output logic                  mret_ack,
    output logic [CNT_W-1:0]      stall_cnt,
    output state_t                fsm_state
);

    localparam int R = NUM_STAGES - 1;

    function automatic logic [R-1:0] low_ones(input int n);
        logic [R-1:0] m;
        m = '0;
        for (int i = 0; i < R; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [R-1:0] one_hot(input int n);
        logic [R-1:0] m;
        m = '0;
        for (int i = 0; i < R; i++) begin
            if (i == n) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Flush covers every register younger than the resolving stage.
    localparam logic [R-1:0] FLUSH_MASK   = low_ones(BR_STAGE);
    localparam logic [R-1:0] MC_HOLD_MASK = low_ones(EXE_STAGE);
    localparam logic [R-1:0] MC_BUBBLE    = one_hot(EXE_STAGE);
    localparam logic [R-1:0] LH_HOLD_MASK = low_ones(EXE_STAGE - 1);
    localparam logic [R-1:0] LH_BUBBLE    = one_hot(EXE_STAGE - 1);

    state_t               state;
    state_t               state_nxt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [DRAIN_W-1:0]   drain_nxt;

    assign fsm_state = state;

    // An external memory stall freezes the controller together with the pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else if (!stall_pipl) begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        drain_nxt      = drain_cnt;
        reg_en         = '1;
        reg_clr        = '0;
        pc_reg_en      = 1'b1;
        redirect_valid = 1'b0;
        redirect_sel   = BRANCH;
        trap_ack       = 1'b0;
        mret_ack       = 1'b0;

        if (stall_pipl) begin
            reg_en    = '0;
            pc_reg_en = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (trap_req) begin
                        reg_clr   = FLUSH_MASK;
                        pc_reg_en = 1'b0;
                        drain_nxt = DRAIN_W'(DRAIN_CYCLES);
                        state_nxt = (DRAIN_CYCLES > 0) ? TRAP_DRAIN : TRAP_REDIR;
                    end else if (mret_req) begin
                        redirect_valid = 1'b1;
                        redirect_sel   = MRET;
                        mret_ack       = 1'b1;
                        reg_clr        = FLUSH_MASK;
                    end else if (branch_taken) begin
                        redirect_valid = 1'b1;
                        redirect_sel   = BRANCH;
                        reg_clr        = FLUSH_MASK;
                    end else if (mc_start && !mc_done) begin
                        state_nxt = MC_WAIT;
                    end else if (load_hazard) begin
                        pc_reg_en = 1'b0;
                        reg_en    = ~LH_HOLD_MASK;
                        reg_clr   = LH_BUBBLE;
                    end
                end

                MC_WAIT: begin
                    // Younger stages hold, a bubble leaves EXE, older stages drain.
                    if (mc_done) begin
                        state_nxt = RUN;
                    end else begin
                        pc_reg_en = 1'b0;
                        reg_en    = ~MC_HOLD_MASK;
                        reg_clr   = MC_BUBBLE;
                    end
                end

                TRAP_DRAIN: begin
                    reg_clr   = FLUSH_MASK;
                    pc_reg_en = 1'b0;
                    if (drain_cnt != '0) drain_nxt = drain_cnt - DRAIN_W'(1);
                    if (drain_cnt <= DRAIN_W'(1)) state_nxt = TRAP_REDIR;
                end

                TRAP_REDIR: begin
                    redirect_valid = 1'b1;
                    redirect_sel   = TRAP;
                    trap_ack       = 1'b1;
                    reg_clr        = FLUSH_MASK;
                    state_nxt      = RUN;
                end

                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~pc_reg_en),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed bench for pipeline_flow_ctrl: a table of single-cycle RUN vectors
// plus hand-written multi-cycle sequences for stalls, traps, reset and saturation.
module tb_pipeline_flow_ctrl;
    import flow_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic stall_pipl, load_hazard, branch_taken, mc_start, mc_done;
    logic trap_req, trap_req0, mret_req, cnt_clr;

    logic [3:0] reg_en, reg_clr, reg_en0, reg_clr0;
    logic       pc_reg_en, redirect_valid, trap_ack, mret_ack;
    logic       pc_reg_en0, redirect_valid0, trap_ack0, mret_ack0;
    logic [1:0] redirect_sel, redirect_sel0;
    logic [3:0] stall_cnt, stall_cnt0;
    state_t     fsm_state, fsm_state0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_flow_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .reset(rst), .stall_pipl(stall_pipl), .load_hazard(load_hazard),
        .branch_taken(branch_taken), .mc_start(mc_start), .mc_done(mc_done),
        .trap_req(trap_req), .mret_req(mret_req), .cnt_clr(cnt_clr),
        .reg_en(reg_en), .reg_clr(reg_clr), .pc_reg_en(pc_reg_en),
        .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
        .trap_ack(trap_ack), .mret_ack(mret_ack), .stall_cnt(stall_cnt),
        .fsm_state(fsm_state)
    );

    pipeline_flow_ctrl #(.DRAIN_CYCLES(0), .CNT_W(4)) dut0 (
        .clk(clk), .reset(rst), .stall_pipl(stall_pipl), .load_hazard(load_hazard),
        .branch_taken(branch_taken), .mc_start(mc_start), .mc_done(mc_done),
        .trap_req(trap_req0), .mret_req(mret_req), .cnt_clr(cnt_clr),
        .reg_en(reg_en0), .reg_clr(reg_clr0), .pc_reg_en(pc_reg_en0),
        .redirect_valid(redirect_valid0), .redirect_sel(redirect_sel0),
        .trap_ack(trap_ack0), .mret_ack(mret_ack0), .stall_cnt(stall_cnt0),
        .fsm_state(fsm_state0)
    );

    typedef struct {
        logic       stall, lh, br, mcs, mcd, trap, mret;
        logic [3:0] en, clr;
        logic       pc, rv;
        logic [1:0] sel;
        logic       tack, mack;
        string      name;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic drive_idle();
        stall_pipl = 0; load_hazard = 0; branch_taken = 0; mc_start = 0; mc_done = 0;
        trap_req = 0; trap_req0 = 0; mret_req = 0; cnt_clr = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v);
        stall_pipl = v.stall; load_hazard = v.lh; branch_taken = v.br;
        mc_start = v.mcs; mc_done = v.mcd; trap_req = v.trap; mret_req = v.mret;
    endtask

    initial begin
        vecs[0]  = '{0,0,0,0,0,0,0, 4'hf,4'h0, 1,0,2'd0,0,0, "idle"};
        vecs[1]  = '{0,1,0,0,0,0,0, 4'he,4'h2, 0,0,2'd0,0,0, "load_hazard"};
        vecs[2]  = '{0,0,1,0,0,0,0, 4'hf,4'h7, 1,1,2'd0,0,0, "branch"};
        vecs[3]  = '{0,1,1,0,0,0,0, 4'hf,4'h7, 1,1,2'd0,0,0, "branch_lh"};
        vecs[4]  = '{0,0,1,1,0,0,0, 4'hf,4'h7, 1,1,2'd0,0,0, "branch_mc"};
        vecs[5]  = '{0,0,0,0,0,0,1, 4'hf,4'h7, 1,1,2'd2,0,1, "mret"};
        vecs[6]  = '{0,0,1,0,0,0,1, 4'hf,4'h7, 1,1,2'd2,0,1, "mret_br"};
        vecs[7]  = '{0,0,0,0,0,1,0, 4'hf,4'h7, 0,0,2'd0,0,0, "trap"};
        vecs[8]  = '{0,0,1,0,0,1,1, 4'hf,4'h7, 0,0,2'd0,0,0, "trap_all"};
        vecs[9]  = '{0,0,0,1,0,0,0, 4'hf,4'h0, 1,0,2'd0,0,0, "mc_start"};
        vecs[10] = '{0,1,0,1,1,0,0, 4'he,4'h2, 0,0,2'd0,0,0, "mc_both_lh"};
        vecs[11] = '{0,1,0,1,0,0,0, 4'hf,4'h0, 1,0,2'd0,0,0, "mc_lh"};
        vecs[12] = '{1,0,0,0,0,1,0, 4'h0,4'h0, 0,0,2'd0,0,0, "stall_trap"};
        vecs[13] = '{1,1,1,0,0,0,0, 4'h0,4'h0, 0,0,2'd0,0,0, "stall_br_lh"};
        vecs[14] = '{0,0,0,0,1,0,0, 4'hf,4'h0, 1,0,2'd0,0,0, "mc_done_only"};

        drive_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", fsm_state, RUN);
        check("rst_cnt", stall_cnt, 0);
        check("rst_reg_en", reg_en, 4'hf);
        check("rst_pc_en", pc_reg_en, 1);
        next_cycle();
        rst = 0;

        // Single-cycle RUN vectors; inputs go idle before each rising edge.
        for (int i = 0; i < 15; i++) begin
            apply_vec(vecs[i]);
            @(negedge clk);
            check($sformatf("%s.reg_en", vecs[i].name), reg_en, vecs[i].en);
            check($sformatf("%s.reg_clr", vecs[i].name), reg_clr, vecs[i].clr);
            check($sformatf("%s.pc_en", vecs[i].name), pc_reg_en, vecs[i].pc);
            check($sformatf("%s.rv", vecs[i].name), redirect_valid, vecs[i].rv);
            check($sformatf("%s.sel", vecs[i].name), redirect_sel, vecs[i].sel);
            check($sformatf("%s.tack", vecs[i].name), trap_ack, vecs[i].tack);
            check($sformatf("%s.mack", vecs[i].name), mret_ack, vecs[i].mack);
            drive_idle();
            next_cycle();
        end
        @(negedge clk);
        check("table_cnt", stall_cnt, 0);
        check("table_state", fsm_state, RUN);
        next_cycle();

        // One-cycle load hazard
        load_hazard = 1;
        @(negedge clk);
        check("lh_pc_en", pc_reg_en, 0);
        next_cycle();
        load_hazard = 0;
        @(negedge clk);
        check("lh_cnt", stall_cnt, 1);
        check("lh_pc_after", pc_reg_en, 1);
        next_cycle();

        // Multi-cycle op: 4 waiting cycles, branch ignored while waiting
        cnt_clr = 1;
        next_cycle();
        cnt_clr = 0;
        mc_start = 1;
        @(negedge clk);
        check("mc0_state", fsm_state, RUN);
        check("mc0_pc_en", pc_reg_en, 1);
        next_cycle();
        for (int k = 1; k <= 4; k++) begin
            branch_taken = (k == 2);
            @(negedge clk);
            check($sformatf("mc%0d_state", k), fsm_state, MC_WAIT);
            check($sformatf("mc%0d_reg_en", k), reg_en, 4'hc);
            check($sformatf("mc%0d_reg_clr", k), reg_clr, 4'h4);
            check($sformatf("mc%0d_pc_en", k), pc_reg_en, 0);
            check($sformatf("mc%0d_rv", k), redirect_valid, 0);
            next_cycle();
        end
        branch_taken = 0;
        mc_done = 1;
        @(negedge clk);
        check("mc_done_reg_en", reg_en, 4'hf);
        check("mc_done_reg_clr", reg_clr, 4'h0);
        check("mc_done_pc_en", pc_reg_en, 1);
        next_cycle();
        drive_idle();
        @(negedge clk);
        check("mc_end_state", fsm_state, RUN);
        check("mc_end_cnt", stall_cnt, 4);
        next_cycle();

        // Trap with DRAIN_CYCLES=1 (dut) and DRAIN_CYCLES=0 (dut0)
        cnt_clr = 1;
        next_cycle();
        cnt_clr = 0;
        trap_req = 1;
        trap_req0 = 1;
        @(negedge clk);
        check("t0_reg_clr", reg_clr, 4'h7);
        check("t0_pc_en", pc_reg_en, 0);
        check("t0_tack", trap_ack, 0);
        check("t0_d0_reg_clr", reg_clr0, 4'h7);
        next_cycle();
        @(negedge clk);
        check("t1_state", fsm_state, TRAP_DRAIN);
        check("t1_reg_clr", reg_clr, 4'h7);
        check("t1_pc_en", pc_reg_en, 0);
        check("t1_tack", trap_ack, 0);
        check("t1_d0_tack", trap_ack0, 1);
        check("t1_d0_rv", redirect_valid0, 1);
        check("t1_d0_sel", redirect_sel0, 1);
        check("t1_d0_pc_en", pc_reg_en0, 1);
        next_cycle();
        trap_req0 = 0;
        @(negedge clk);
        check("t2_state", fsm_state, TRAP_REDIR);
        check("t2_tack", trap_ack, 1);
        check("t2_rv", redirect_valid, 1);
        check("t2_sel", redirect_sel, 1);
        check("t2_pc_en", pc_reg_en, 1);
        check("t2_reg_clr", reg_clr, 4'h7);
        check("t2_d0_state", fsm_state0, RUN);
        check("t2_d0_tack", trap_ack0, 0);
        next_cycle();
        trap_req = 0;
        @(negedge clk);
        check("t3_state", fsm_state, RUN);
        check("t3_tack", trap_ack, 0);
        check("t3_cnt", stall_cnt, 2);
        check("t3_d0_cnt", stall_cnt0, 1);
        next_cycle();

        // External stall during drain delays the ack by exactly 3 cycles
        trap_req = 1;
        next_cycle();
        stall_pipl = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("sd%0d_state", k), fsm_state, TRAP_DRAIN);
            check($sformatf("sd%0d_reg_en", k), reg_en, 4'h0);
            check($sformatf("sd%0d_reg_clr", k), reg_clr, 4'h0);
            check($sformatf("sd%0d_tack", k), trap_ack, 0);
            next_cycle();
        end
        stall_pipl = 0;
        @(negedge clk);
        check("sd4_state", fsm_state, TRAP_DRAIN);
        check("sd4_tack", trap_ack, 0);
        check("sd4_reg_clr", reg_clr, 4'h7);
        next_cycle();
        @(negedge clk);
        check("sd5_tack", trap_ack, 1);
        check("sd5_sel", redirect_sel, 1);
        next_cycle();
        trap_req = 0;
        @(negedge clk);
        check("sd6_state", fsm_state, RUN);
        next_cycle();

        // Trap held during MC_WAIT is deferred, then reset abandons it
        mc_start = 1;
        next_cycle();
        trap_req = 1;
        @(negedge clk);
        check("mt_state", fsm_state, MC_WAIT);
        check("mt_reg_clr", reg_clr, 4'h4);
        check("mt_tack", trap_ack, 0);
        next_cycle();
        mc_done = 1;
        @(negedge clk);
        check("mt_done_reg_en", reg_en, 4'hf);
        check("mt_done_reg_clr", reg_clr, 4'h0);
        next_cycle();
        mc_start = 0;
        mc_done = 0;
        @(negedge clk);
        check("mt_run_reg_clr", reg_clr, 4'h7);
        check("mt_run_pc_en", pc_reg_en, 0);
        next_cycle();
        @(negedge clk);
        check("mt_drain_state", fsm_state, TRAP_DRAIN);
        rst = 1;
        #1;
        check("mt_rst_state", fsm_state, RUN);
        trap_req = 0;
        next_cycle();
        rst = 0;
        @(negedge clk);
        check("mt_post_state", fsm_state, RUN);
        check("mt_post_tack", trap_ack, 0);
        next_cycle();

        // Asynchronous reset in the middle of MC_WAIT
        mc_start = 1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rmc_state", fsm_state, MC_WAIT);
        rst = 1;
        #1;
        check("rmc_rst_state", fsm_state, RUN);
        check("rmc_rst_cnt", stall_cnt, 0);
        check("rmc_rst_d0_cnt", stall_cnt0, 0);
        mc_start = 0;
        next_cycle();
        rst = 0;
        next_cycle();

        // Saturation and clear priority
        stall_pipl = 1;
        repeat (16) next_cycle();
        @(negedge clk);
        check("sat16_cnt", stall_cnt, 4'hf);
        repeat (4) next_cycle();
        @(negedge clk);
        check("sat20_cnt", stall_cnt, 4'hf);
        cnt_clr = 1;
        next_cycle();
        cnt_clr = 0;
        @(negedge clk);
        check("sat_clr_cnt", stall_cnt, 0);
        next_cycle();
        @(negedge clk);
        check("sat_after_cnt", stall_cnt, 1);
        drive_idle();
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
